// File: rtl/cmd_responder_if.sv
// Command/reply byte streams and register bus of the FX2 command endpoint.
interface cmd_responder_if;
    logic        cmd_wr;
    logic [7:0]  cmd_in;
    logic        reply_rdy;
    logic [7:0]  reply;
    logic        reply_ack;
    logic        reply_end;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        cmd_dropped;
    logic        timeout_err;

    modport slave (
        input  cmd_wr, cmd_in, reply_ack, reg_rdata,
        output reply_rdy, reply, reply_end,
        output reg_addr, reg_wdata, reg_wr, reg_rd,
        output cmd_dropped, timeout_err
    );

    modport master (
        output cmd_wr, cmd_in, reply_ack, reg_rdata,
        input  reply_rdy, reply, reply_end,
        input  reg_addr, reg_wdata, reg_wr, reg_rd,
        input  cmd_dropped, timeout_err
    );
endinterface

// File: rtl/cmd_responder.sv
// FX2 command decoder: framed ping/read/write to a register bus, framed replies.
// Optional CMD_TIMEOUT_EN abandons partial frames after TIMEOUT_CYCLES idle cycles.
module cmd_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            fx2_clk,
    input  logic            reset,
    cmd_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, RDREQ, RDWAIT, REPLY
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  op_q;
    logic [7:0]  addr_q;
    logic [31:0] shift_q;
    logic [2:0]  cnt_q;
    logic [7:0]  hdr_q;
    logic [2:0]  last_q;
    logic        busy;
    logic        timeout_hit;

    assign busy = (state == RDREQ) || (state == RDWAIT) ||
                  (state == REPLY);

    always_ff @(posedge fx2_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.cmd_wr) begin
                    unique case (1'b1)
                        (bus.cmd_in == 8'h01),
                        (bus.cmd_in == 8'h02): state_nx = ADDR;
                        default:               state_nx = REPLY;
                    endcase
                end
            end
            ADDR: begin
                if (bus.cmd_wr)
                    state_nx = (op_q == 8'h01) ? WDATA : RDREQ;
                else if (timeout_hit)
                    state_nx = IDLE;
            end
            WDATA: begin
                if (bus.cmd_wr && cnt_q == 3'd3)
                    state_nx = REPLY;
                else if (timeout_hit)
                    state_nx = IDLE;
            end
            RDREQ:  state_nx = RDWAIT;
            RDWAIT: state_nx = REPLY;
            REPLY: begin
                if (bus.reply_ack && cnt_q == last_q)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // shift_q doubles as write-data assembly and captured read data
    always_ff @(posedge fx2_clk) begin
        if (reset) begin
            op_q            <= 8'h00;
            addr_q          <= 8'h00;
            shift_q         <= 32'h0;
            cnt_q           <= 3'd0;
            hdr_q           <= 8'h00;
            last_q          <= 3'd0;
            bus.reg_addr    <= 8'h00;
            bus.reg_wdata   <= 32'h0;
            bus.reg_wr      <= 1'b0;
            bus.cmd_dropped <= 1'b0;
        end else begin
            bus.reg_wr      <= 1'b0;
            bus.cmd_dropped <= bus.cmd_wr && busy;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_wr) begin
                        op_q   <= bus.cmd_in;
                        cnt_q  <= 3'd0;
                        last_q <= 3'd0;
                        hdr_q  <= (bus.cmd_in == 8'h00) ? 8'hA5
                                                        : 8'hFF;
                    end
                end
                ADDR: begin
                    if (bus.cmd_wr) begin
                        addr_q <= bus.cmd_in;
                        cnt_q  <= 3'd0;
                        if (op_q == 8'h02)
                            bus.reg_addr <= bus.cmd_in;
                    end
                end
                WDATA: begin
                    if (bus.cmd_wr) begin
                        shift_q <= {bus.cmd_in, shift_q[31:8]};
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd3) begin
                            bus.reg_wr    <= 1'b1;
                            bus.reg_addr  <= addr_q;
                            bus.reg_wdata <= {bus.cmd_in,
                                              shift_q[31:8]};
                            cnt_q  <= 3'd0;
                            hdr_q  <= 8'h00;
                            last_q <= 3'd0;
                        end
                    end
                end
                RDWAIT: begin
                    shift_q <= bus.reg_rdata;
                    hdr_q   <= 8'h00;
                    last_q  <= 3'd4;
                    cnt_q   <= 3'd0;
                end
                REPLY: begin
                    if (bus.reply_ack && cnt_q != last_q)
                        cnt_q <= cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.reg_rd    = (state == RDREQ);
        bus.reply_rdy = (state == REPLY);
        bus.reply_end = (state == REPLY) && (cnt_q == last_q);
        bus.reply     = 8'h00;
        if (state == REPLY) begin
            unique case (cnt_q)
                3'd0:    bus.reply = hdr_q;
                3'd1:    bus.reply = shift_q[7:0];
                3'd2:    bus.reply = shift_q[15:8];
                3'd3:    bus.reply = shift_q[23:16];
                3'd4:    bus.reply = shift_q[31:24];
                default: bus.reply = 8'h00;
            endcase
        end
    end

`ifdef CMD_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_err_q;

    always_comb begin
        timeout_hit = ((state == ADDR) || (state == WDATA)) &&
                      !bus.cmd_wr &&
                      (to_cnt == 16'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge fx2_clk) begin
        if (reset) begin
            to_cnt   <= 16'd0;
            to_err_q <= 1'b0;
        end else begin
            to_err_q <= timeout_hit;
            if (bus.cmd_wr || !((state == ADDR) || (state == WDATA)))
                to_cnt <= 16'd0;
            else
                to_cnt <= to_cnt + 16'd1;
        end
    end

    assign bus.timeout_err = to_err_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder: write, read, ping, invalid,
// reply backpressure, dropped bytes and reset mid-reply.
module tb_cmd_responder;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    cmd_responder_if bus ();

    cmd_responder #(.TIMEOUT_CYCLES(8)) dut (
        .fx2_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    // Register file model: read data valid only in the cycle after reg_rd
    always @(posedge clk)
        bus.reg_rdata <= bus.reg_rd ? 32'hDEADBEEF : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.cmd_wr = 1'b1;
        bus.cmd_in = b;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.cmd_wr = 1'b0;
    endtask

    logic [7:0]  exp_rd [5];
    logic [15:0] pat;
    int          idx;

    initial begin
        exp_rd[0] = 8'h00; exp_rd[1] = 8'hEF; exp_rd[2] = 8'hBE;
        exp_rd[3] = 8'hAD; exp_rd[4] = 8'hDE;
        pat = 16'b1011_0011_1010_0110;
        reset = 1'b1;
        bus.cmd_wr = 1'b0;
        bus.cmd_in = 8'h00;
        bus.reply_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", bus.reply_rdy, 0);
        chk("rst_reply", bus.reply, 0);
        chk("rst_end", bus.reply_end, 0);
        chk("rst_wr", bus.reg_wr, 0);
        chk("rst_rd", bus.reg_rd, 0);
        chk("rst_addr", bus.reg_addr, 0);
        chk("rst_wdata", bus.reg_wdata, 0);
        chk("rst_drop", bus.cmd_dropped, 0);
        chk("rst_to", bus.timeout_err, 0);
        reset = 1'b0;

        // write 01 10 78 56 34 12
        put(8'h01); put(8'h10); put(8'h78);
        put(8'h56); put(8'h34); put(8'h12);
        chk("wr_early", bus.reg_wr, 0);
        idle();
        chk("wr_strobe", bus.reg_wr, 1);
        chk("wr_addr", bus.reg_addr, 32'h10);
        chk("wr_data", bus.reg_wdata, 32'h12345678);
        chk("wr_rdy", bus.reply_rdy, 1);
        chk("wr_reply", bus.reply, 32'h00);
        chk("wr_end", bus.reply_end, 1);
        bus.reply_ack = 1'b1;
        @(negedge clk);
        chk("wr_pulse", bus.reg_wr, 0);
        chk("wr_done", bus.reply_rdy, 0);
        bus.reply_ack = 1'b0;

        // read 02 10 with backpressure and a byte during REPLY
        put(8'h02); put(8'h10);
        idle();
        chk("rd_strobe", bus.reg_rd, 1);
        chk("rd_addr", bus.reg_addr, 32'h10);
        chk("rd_rdy_n1", bus.reply_rdy, 0);
        @(negedge clk);
        chk("rd_pulse", bus.reg_rd, 0);
        chk("rd_rdy_n2", bus.reply_rdy, 0);
        @(negedge clk);
        chk("rd_rdy_n3", bus.reply_rdy, 1);
        chk("rd_hdr", bus.reply, 32'h00);
        bus.cmd_wr = 1'b1;
        bus.cmd_in = 8'h55;
        @(negedge clk);
        bus.cmd_wr = 1'b0;
        chk("drop_pulse", bus.cmd_dropped, 1);
        chk("drop_hold", bus.reply, 32'h00);
        idx = 0;
        for (int k = 0; k < 40 && idx < 5; k++) begin
            bus.reply_ack = pat[k % 16];
            chk("rd_rdy", bus.reply_rdy, 1);
            chk("rd_byte", bus.reply, exp_rd[idx]);
            chk("rd_end", bus.reply_end, (idx == 4) ? 1 : 0);
            if (bus.reply_ack) idx++;
            @(negedge clk);
        end
        bus.reply_ack = 1'b0;
        chk("rd_count", idx, 5);
        chk("rd_done", bus.reply_rdy, 0);
        chk("hold_wdata", bus.reg_wdata, 32'h12345678);

        // ping right after reply_rdy dropped
        bus.cmd_wr = 1'b1;
        bus.cmd_in = 8'h00;
        idle();
        chk("ping_rdy", bus.reply_rdy, 1);
        chk("ping_reply", bus.reply, 32'hA5);
        chk("ping_end", bus.reply_end, 1);
        chk("ping_nodrop", bus.cmd_dropped, 0);
        bus.reply_ack = 1'b1;
        @(negedge clk);
        chk("ping_done", bus.reply_rdy, 0);
        bus.reply_ack = 1'b0;

        // invalid opcode
        put(8'h7F);
        idle();
        chk("inv_reply", bus.reply, 32'hFF);
        chk("inv_end", bus.reply_end, 1);
        bus.reply_ack = 1'b1;
        @(negedge clk);
        chk("inv_done", bus.reply_rdy, 0);

        // back-to-back read with ack held high
        put(8'h02); put(8'h33);
        idle();
        chk("b2b_addr", bus.reg_addr, 32'h33);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("b2b_rdy", bus.reply_rdy, 1);
            chk("b2b_byte", bus.reply, exp_rd[k]);
            @(negedge clk);
        end
        chk("b2b_done", bus.reply_rdy, 0);
        bus.reply_ack = 1'b0;

        // reset in the middle of a reply
        put(8'h02); put(8'h10);
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("mid_rdy", bus.reply_rdy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy", bus.reply_rdy, 0);
        chk("mid_rst_rd", bus.reg_rd, 0);
        reset = 1'b0;
        put(8'h00);
        idle();
        chk("post_rst_ping", bus.reply, 32'hA5);
        bus.reply_ack = 1'b1;
        @(negedge clk);
        bus.reply_ack = 1'b0;

`ifdef CMD_TIMEOUT_EN
        put(8'h01); put(8'h10); put(8'hAA);
        idle();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("to_early", bus.timeout_err, 0);
        end
        @(negedge clk);
        chk("to_pulse", bus.timeout_err, 1);
        chk("to_nowr", bus.reg_wr, 0);
        chk("to_noreply", bus.reply_rdy, 0);
        put(8'h00);
        idle();
        chk("to_ping", bus.reply, 32'hA5);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
